// File: rtl/pipe_ifid.sv
// pipe_ifid: IF/ID pipeline register between fetch and decode.
// Ports: clock, clear (async active-high reset), enable (0 = stall), flush (bubble, beats enable),
//   instruction/pc/validIn from fetch; instructionOut/pcOut/validOut registered for decode,
//   pcPlus4Out = pcOut + PC_STEP (combinational, wraps), stallCount (stall-cycle counter).
// Optional: define PIPE_IFID_STALL_CNT_EN to build the saturating stall counter; otherwise stallCount is 0.
module pipe_ifid #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  validIn,
    output logic [DATA_WIDTH-1:0] instructionOut,
    output logic [DATA_WIDTH-1:0] pcOut,
    output logic [DATA_WIDTH-1:0] pcPlus4Out,
    output logic                  validOut,
    output logic [15:0]           stallCount
);
    logic [DATA_WIDTH-1:0] instr_q, instr_d, pc_q, pc_d;
    logic                  valid_q, valid_d;

    always_comb begin
        instr_d = flush ? NOP_INSTR : enable ? instruction : instr_q;
        pc_d    = (flush || enable) ? pc : pc_q;
        valid_d = flush ? 1'b0 : enable ? validIn : valid_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instructionOut = instr_q;
    assign pcOut          = pc_q;
    assign validOut       = valid_q;
    assign pcPlus4Out     = pc_q + DATA_WIDTH'(PC_STEP);

`ifdef PIPE_IFID_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Counts only stalls that hold a valid instruction; any load or flush restarts it.
    always_comb begin
        stall_d = (flush || enable) ? 16'h0000 :
                  (valid_q && stall_q != 16'hFFFF) ? stall_q + 16'h0001 : stall_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) stall_q <= 16'h0000;
        else       stall_q <= stall_d;
    end

    assign stallCount = stall_q;
`else
    assign stallCount = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_ifid.sv
// tb_pipe_ifid: directed self-checking bench for pipe_ifid.
module tb_pipe_ifid;
    logic        clock = 1'b0;
    logic        clear, enable, flush, validIn;
    logic [31:0] instruction, pc;
    logic [31:0] instructionOut, pcOut, pcPlus4Out;
    logic        validOut;
    logic [15:0] stallCount;
    int          total = 0;
    int          bad   = 0;

    pipe_ifid dut (
        .clock(clock), .clear(clear), .enable(enable), .flush(flush),
        .instruction(instruction), .pc(pc), .validIn(validIn),
        .instructionOut(instructionOut), .pcOut(pcOut), .pcPlus4Out(pcPlus4Out),
        .validOut(validOut), .stallCount(stallCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] sc(input logic [31:0] v);
`ifdef PIPE_IFID_STALL_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        clear = 1'b1; enable = 1'b0; flush = 1'b0; validIn = 1'b0;
        instruction = 32'h0; pc = 32'h0;
        #2;
        chk("rst_instr", instructionOut, 32'h0);
        chk("rst_pc", pcOut, 32'h0);
        chk("rst_pc4", pcPlus4Out, 32'h4);
        chk("rst_valid", {31'b0, validOut}, 32'h0);
        chk("rst_stall", {16'b0, stallCount}, 32'h0);
        tick();
        clear = 1'b0;
        enable = 1'b1; instruction = 32'h1234_5678; pc = 32'h8765_4321; validIn = 1'b1;
        tick();
        chk("ld_instr", instructionOut, 32'h1234_5678);
        chk("ld_pc", pcOut, 32'h8765_4321);
        chk("ld_pc4", pcPlus4Out, 32'h8765_4325);
        chk("ld_valid", {31'b0, validOut}, 32'h1);
        #2 clear = 1'b1;
        #1;
        chk("aclr_instr", instructionOut, 32'h0);
        chk("aclr_pc", pcOut, 32'h0);
        chk("aclr_valid", {31'b0, validOut}, 32'h0);
        tick();
        chk("aclr_hold_instr", instructionOut, 32'h0);
        chk("aclr_hold_valid", {31'b0, validOut}, 32'h0);
        clear = 1'b0;
        tick();
        chk("reld_instr", instructionOut, 32'h1234_5678);
        chk("reld_pc", pcOut, 32'h8765_4321);
        chk("reld_valid", {31'b0, validOut}, 32'h1);
        enable = 1'b0; instruction = 32'hDEAD_BEEF; pc = 32'h0000_0100;
        tick();
        chk("stall1_instr", instructionOut, 32'h1234_5678);
        chk("stall1_cnt", {16'b0, stallCount}, sc(32'h1));
        tick();
        chk("stall2_instr", instructionOut, 32'h1234_5678);
        chk("stall2_pc", pcOut, 32'h8765_4321);
        chk("stall2_cnt", {16'b0, stallCount}, sc(32'h2));
        enable = 1'b1;
        tick();
        chk("resume_instr", instructionOut, 32'hDEAD_BEEF);
        chk("resume_pc", pcOut, 32'h0000_0100);
        chk("resume_cnt", {16'b0, stallCount}, 32'h0);
        flush = 1'b1; instruction = 32'hAAAA_5555; pc = 32'h40;
        tick();
        chk("fl_instr", instructionOut, 32'h0);
        chk("fl_pc", pcOut, 32'h40);
        chk("fl_pc4", pcPlus4Out, 32'h44);
        chk("fl_valid", {31'b0, validOut}, 32'h0);
        flush = 1'b0; enable = 1'b0; pc = 32'h80;
        tick();
        chk("empty_stall_pc", pcOut, 32'h40);
        chk("empty_stall_cnt", {16'b0, stallCount}, 32'h0);
        enable = 1'b1; pc = 32'hFFFF_FFFC; instruction = 32'h0000_0013;
        tick();
        chk("wrap_pc", pcOut, 32'hFFFF_FFFC);
        chk("wrap_pc4", pcPlus4Out, 32'h0);
        chk("wrap_instr", instructionOut, 32'h0000_0013);
        enable = 1'b0; flush = 1'b1;
        tick();
        chk("fl_noen_instr", instructionOut, 32'h0);
        chk("fl_noen_valid", {31'b0, validOut}, 32'h0);
        flush = 1'b0; enable = 1'b1; instruction = 32'h1111_2222; pc = 32'h200;
        tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("pre_clr_cnt", {16'b0, stallCount}, sc(32'h3));
        #2 clear = 1'b1;
        #1;
        chk("midstall_clr_cnt", {16'b0, stallCount}, 32'h0);
        chk("midstall_clr_valid", {31'b0, validOut}, 32'h0);
        tick();
        clear = 1'b0;
        tick();
        chk("post_clr_empty", {31'b0, validOut}, 32'h0);
        chk("post_clr_cnt", {16'b0, stallCount}, 32'h0);
`ifdef PIPE_IFID_STALL_CNT_EN
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (65540) tick();
        chk("sat_cnt", {16'b0, stallCount}, 32'h0000_FFFF);
        chk("sat_instr", instructionOut, 32'h1111_2222);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
